// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The state enum, forwarding select codes and the load result-source code live here.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } memstate_t;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline control fields observed by the hazard controller and the
// stall/flush/forward controls it returns to the datapath.
interface pipeline_hazard_ctrl_if;

    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MemErr;
    logic [31:0] StallCnt, FlushCnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemErr, StallCnt, FlushCnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemErr, StallCnt, FlushCnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// EX operand forwarding selection for both ALU operands.
// A Memory-stage producer takes priority over a Writeback-stage producer.
module forward_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_rs1E,
    input  logic [4:0] i_rs2E,
    input  logic [4:0] i_rdM,
    input  logic       i_regWriteM,
    input  logic [4:0] i_rdW,
    input  logic       i_regWriteW,
    output logic [1:0] o_fwdA,
    output logic [1:0] o_fwdB
);

    function automatic logic [1:0] selectSource(
        input logic [4:0] rs,
        input logic [4:0] rdM,
        input logic       regWriteM,
        input logic [4:0] rdW,
        input logic       regWriteW
    );
        if (regWriteM && (rdM != 5'd0) && (rdM == rs))
            return FWD_MEM;
        else if (regWriteW && (rdW != 5'd0) && (rdW == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign o_fwdA = selectSource(i_rs1E, i_rdM, i_regWriteM, i_rdW, i_regWriteW);
    assign o_fwdB = selectSource(i_rs2E, i_rdM, i_regWriteM, i_rdW, i_regWriteW);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/forward controller with a data-memory wait FSM and timeout.
// Define PIPE_PERF_CNT_EN to build the stall and flush performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    memstate_t     r_state, w_nextState;
    logic [CW-1:0] r_cnt, w_nextCnt;
    logic          r_memErr;
    logic          w_timeout, w_memstall, w_lu;
    logic          w_stallF, w_stallD, w_stallE, w_stallM;
    logic          w_flushD, w_flushE, w_flushW;
    logic [1:0]    w_fwdA, w_fwdB;

    assign w_timeout  = (r_state == MEM_WAIT) && (r_cnt == CW'(MEM_TIMEOUT));
    assign w_memstall = bus.MemReqM && !bus.MemReadyM && !w_timeout;
    assign w_lu       = (bus.ResultSrcE == RESULT_LOAD) && (bus.RdE != 5'd0) &&
                        ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_cnt    <= '0;
            r_memErr <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            if (w_timeout)
                r_memErr <= 1'b1;
        end
    end

    // Leaving MEM_WAIT covers ready, timeout and a dropped request alike.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        case (r_state)
            RUN: begin
                if (w_memstall) begin
                    w_nextState = MEM_WAIT;
                    w_nextCnt   = CW'(1);
                end
            end
            MEM_WAIT: begin
                if (w_memstall) begin
                    w_nextCnt = r_cnt + CW'(1);
                end else begin
                    w_nextState = RUN;
                    w_nextCnt   = '0;
                end
            end
            default: begin
                w_nextState = RUN;
                w_nextCnt   = '0;
            end
        endcase
    end

    // Memory stall outranks a taken branch, which outranks a load-use bubble.
    always_comb begin
        w_stallF = 1'b0;
        w_stallD = 1'b0;
        w_stallE = 1'b0;
        w_stallM = 1'b0;
        w_flushD = 1'b0;
        w_flushE = 1'b0;
        w_flushW = 1'b0;
        if (rst) begin
            w_flushD = 1'b1;
            w_flushE = 1'b1;
            w_flushW = 1'b1;
        end else if (w_memstall) begin
            w_stallF = 1'b1;
            w_stallD = 1'b1;
            w_stallE = 1'b1;
            w_stallM = 1'b1;
            w_flushW = 1'b1;
        end else if (bus.PCSrcE) begin
            w_flushD = 1'b1;
            w_flushE = 1'b1;
        end else if (w_lu) begin
            w_stallF = 1'b1;
            w_stallD = 1'b1;
            w_flushE = 1'b1;
        end
    end

    forward_unit u_fwd (
        .i_rs1E      (bus.Rs1E),
        .i_rs2E      (bus.Rs2E),
        .i_rdM       (bus.RdM),
        .i_regWriteM (bus.RegWriteM),
        .i_rdW       (bus.RdW),
        .i_regWriteW (bus.RegWriteW),
        .o_fwdA      (w_fwdA),
        .o_fwdB      (w_fwdB)
    );

    assign bus.StallF    = w_stallF;
    assign bus.StallD    = w_stallD;
    assign bus.StallE    = w_stallE;
    assign bus.StallM    = w_stallM;
    assign bus.FlushD    = w_flushD;
    assign bus.FlushE    = w_flushE;
    assign bus.FlushW    = w_flushW;
    assign bus.ForwardAE = rst ? FWD_RF : w_fwdA;
    assign bus.ForwardBE = rst ? FWD_RF : w_fwdB;
    assign bus.MemErr    = r_memErr;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stallCnt, r_flushCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_stallF)
                r_stallCnt <= r_stallCnt + 32'd1;
            if (w_flushD || w_flushE || w_flushW)
                r_flushCnt <= r_flushCnt + 32'd1;
        end
    end

    assign bus.StallCnt = r_stallCnt;
    assign bus.FlushCnt = r_flushCnt;
`else
    assign bus.StallCnt = 32'd0;
    assign bus.FlushCnt = 32'd0;
`endif

endmodule
